rgb_pwm_sequencer: RTL and testbench

RGB_PWM_SEQUENCER -- requirements
Module: rgb_pwm_sequencer

---
 rtl/rgb_pwm_sequencer.sv | 156 +++++++++++++++
 tb/tb_rgb_pwm_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_sequencer.sv
// RGB PWM sequencer: a FWFT FIFO of packed duty words feeds CH PWM channels. Words
// are advanced either manually (step) or after a programmable number of PWM periods.
module rgb_pwm_sequencer #(
    parameter int CH    = 3,
    parameter int DW    = 4,
    parameter int DEPTH = 16,
    parameter int HW    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         enable,
    input  logic                         mode,
    input  logic                         step,
    input  logic [HW-1:0]                hold,
    input  logic                         wr_en,
    input  logic [CH*DW-1:0]             wr_data,
    output logic [CH-1:0]                pwm,
    output logic [CH*DW-1:0]             duty_out,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int WW = CH*DW;
    localparam logic [DW-1:0] PLAST = {{(DW-1){1'b1}}, 1'b0};

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic [WW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underrun_q, underrun_d;
    logic          state_q, state_d;
    logic [DW-1:0] pcnt_q, pcnt_d;
    logic [WW-1:0] duty_q, duty_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          req_q, req_d;
    logic [CH-1:0] pwm_q, pwm_d;

    logic          empty_w, full_w, push, pop, boundary, want;
    logic [HW:0]   hmax;
    logic [WW-1:0] head;

    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == CW'(DEPTH));
    assign head     = mem_q[rptr_q];
    assign boundary = (state_q == S_RUN) && tick && (pcnt_q == PLAST);
    assign hmax     = (hold == '0) ? (HW+1)'(1) : {1'b0, hold};
    // A word's hold budget is judged against the count it will have after this boundary.
    assign want     = req_q || (!mode && step) ||
                      (mode && (({1'b0, hcnt_q} + (HW+1)'(1)) >= hmax));

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        duty_d     = duty_q;
        hcnt_d     = hcnt_q;
        req_d      = req_q;
        underrun_d = underrun_q;
        pop        = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            pcnt_d  = '0;
            duty_d  = '0;
            hcnt_d  = '0;
            req_d   = 1'b0;
        end else if (state_q == S_IDLE) begin
            if (!empty_w) begin
                pop     = 1'b1;
                state_d = S_RUN;
                duty_d  = head;
            end
        end else begin
            if (tick) pcnt_d = boundary ? '0 : pcnt_q + 1'b1;
            if (boundary) begin
                if (want && !empty_w) begin
                    pop    = 1'b1;
                    duty_d = head;
                    hcnt_d = '0;
                    req_d  = 1'b0;
                end else begin
                    if (hcnt_q != '1) hcnt_d = hcnt_q + 1'b1;
                    if (want) begin
                        req_d = 1'b1;
                        if (mode) underrun_d = 1'b1;
                    end
                end
            end else if (!mode && step) begin
                req_d = 1'b1;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a push at full is only dropped without one.
    assign push       = wr_en && (!full_w || pop);
    assign overflow_d = overflow_q || (wr_en && !push);

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_comb begin
        pwm_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            pwm_d[i] = (pcnt_d < duty_d[i*DW +: DW]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            state_q    <= S_IDLE;
            pcnt_q     <= '0;
            duty_q     <= '0;
            hcnt_q     <= '0;
            req_q      <= 1'b0;
            pwm_q      <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            duty_q     <= duty_d;
            hcnt_q     <= hcnt_d;
            req_q      <= req_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm      = pwm_q;
    assign duty_out = duty_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Self-checking bench for rgb_pwm_sequencer: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_rgb_pwm_sequencer;
    localparam int CH = 3, DW = 4, DEPTH = 16, HW = 8;
    localparam int PER = 15;

    logic        clk = 1'b0;
    logic        rst, tick, enable, mode, step, wr_en;
    logic [7:0]  hold;
    logic [11:0] wr_data;
    logic [2:0]  pwm;
    logic [11:0] duty_out;
    logic        full, empty, overflow, underrun;
    logic [4:0]  count;

    int compared = 0, mismatched = 0;

    logic [11:0] mq[$];
    bit          m_run, m_req, m_ovf, m_udr;
    int          m_pc, m_hc;
    logic [11:0] m_duty;

    always #5 clk = ~clk;

    rgb_pwm_sequencer #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .HW(HW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable), .mode(mode), .step(step),
        .hold(hold), .wr_en(wr_en), .wr_data(wr_data), .pwm(pwm), .duty_out(duty_out),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .underrun(underrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_req = 0; m_ovf = 0; m_udr = 0;
        m_pc = 0; m_hc = 0; m_duty = '0;
    endtask

    // One clock of the sequencer described by its rules, using the inputs present at the edge.
    task automatic model_step();
        int          n = mq.size();
        bit          popped = 0;
        bit          at_end = m_run && tick && (m_pc == PER - 1);
        int          budget = (hold == 0) ? 1 : int'(hold);
        bit          wants = m_req || (!mode && step) || (mode && (m_hc + 1 >= budget));
        logic [11:0] front = (n > 0) ? mq[0] : 12'h000;
        if (!enable) begin
            m_run = 0; m_pc = 0; m_duty = '0; m_hc = 0; m_req = 0;
        end else if (!m_run) begin
            if (n > 0) begin
                popped = 1; m_run = 1; m_duty = front;
            end
        end else begin
            if (tick) m_pc = (m_pc + 1) % PER;
            if (at_end) begin
                if (wants && n > 0) begin
                    popped = 1; m_duty = front; m_hc = 0; m_req = 0;
                end else begin
                    m_hc = (m_hc < 255) ? m_hc + 1 : 255;
                    if (wants) begin
                        m_req = 1;
                        if (mode) m_udr = 1;
                    end
                end
            end else if (!mode && step) begin
                m_req = 1;
            end
        end
        if (popped) void'(mq.pop_front());
        if (wr_en) begin
            if (n < DEPTH || popped) mq.push_back(wr_data);
            else m_ovf = 1;
        end
    endtask

    function automatic logic [2:0] model_pwm();
        logic [2:0] p;
        for (int c = 0; c < CH; c++) p[c] = (m_pc < int'(m_duty[c*DW +: DW]));
        return p;
    endfunction

    task automatic check_all();
        check("duty_out", 32'(duty_out), 32'(m_duty));
        check("pwm", 32'(pwm), 32'(model_pwm()));
        check("count", 32'(count), 32'(mq.size()));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underrun", 32'(underrun), 32'(m_udr));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic push_word(input logic [11:0] w);
        wr_en = 1'b1; wr_data = w;
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        int h0, h1, h2, n;
        logic [11:0] wa, wb, ww;
        rst = 1'b0; tick = 1'b1; enable = 1'b0; mode = 1'b0; step = 1'b0;
        hold = 8'd0; wr_en = 1'b0; wr_data = '0;
        model_reset();
        #3;
        check("rst_pwm", 32'(pwm), 32'h0);
        check("rst_duty", 32'(duty_out), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_flags", 32'({overflow, underrun}), 32'h0);
        #20;
        rst = 1'b1;

        // Scenario 1: F80 gives 15/8/0 high ticks per period on channels 2/1/0
        enable = 1'b1;
        push_word(12'hF80);
        cyc();
        check("s1_duty", 32'(duty_out), 32'hF80);
        h0 = 0; h1 = 0; h2 = 0;
        for (int k = 0; k < PER; k++) begin
            cyc();
            h0 += int'(pwm[0]); h1 += int'(pwm[1]); h2 += int'(pwm[2]);
        end
        check("s1_high2", 32'(h2), 32'd15);
        check("s1_high1", 32'(h1), 32'd8);
        check("s1_high0", 32'(h0), 32'd0);
        enable = 1'b0;
        cyc();

        // Scenario 2: auto mode, hold=2 -> A shown for 30 ticks, then B
        do_reset();
        mode = 1'b1; hold = 8'd2; wa = 12'h3A5; wb = 12'h7C1;
        push_word(wa);
        push_word(wb);
        enable = 1'b1;
        cyc();
        n = (duty_out == wa) ? 1 : 0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (duty_out != wa) break;
            n++;
        end
        check("s2_a_ticks", 32'(n), 32'd30);
        check("s2_b_loaded", 32'(duty_out), 32'(wb));
        enable = 1'b0;
        cyc();

        // Scenario 3: hold=0, single word -> underrun after one period, duty kept
        do_reset();
        mode = 1'b1; hold = 8'd0; ww = 12'h5A3;
        push_word(ww);
        enable = 1'b1;
        cyc();
        for (int k = 0; k < PER - 1; k++) cyc();
        check("s3_no_udr_yet", 32'(underrun), 32'h0);
        cyc();
        check("s3_udr", 32'(underrun), 32'h1);
        check("s3_duty_kept", 32'(duty_out), 32'(ww));
        h0 = 0; h1 = 0; h2 = 0;
        for (int k = 0; k < PER; k++) begin
            cyc();
            h0 += int'(pwm[0]); h1 += int'(pwm[1]); h2 += int'(pwm[2]);
        end
        check("s3_high0", 32'(h0), 32'd3);
        check("s3_high1", 32'(h1), 32'd10);
        check("s3_high2", 32'(h2), 32'd5);
        enable = 1'b0;
        cyc();

        // Scenario 4: fill, overflow, push+pop at full
        do_reset();
        mode = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_word(12'(i * 37 + 1));
        check("s4_full", 32'(full), 32'h1);
        check("s4_count16", 32'(count), 32'd16);
        check("s4_no_ovf", 32'(overflow), 32'h0);
        push_word(12'hABC);
        check("s4_ovf", 32'(overflow), 32'h1);
        check("s4_count_kept", 32'(count), 32'd16);
        enable = 1'b1; wr_en = 1'b1; wr_data = 12'h123;
        cyc();
        wr_en = 1'b0;
        check("s4_pushpop_count", 32'(count), 32'd16);
        check("s4_head_loaded", 32'(duty_out), 32'd1);
        enable = 1'b0;
        cyc();

        // Scenario 5: manual steps mid-period take effect at the boundary, one pop
        do_reset();
        mode = 1'b0;
        push_word(12'h111);
        push_word(12'h222);
        push_word(12'h333);
        enable = 1'b1;
        cyc();
        for (int k = 0; k < 20 && m_pc != 3; k++) cyc();
        step = 1'b1; cyc(); step = 1'b0;
        check("s5_no_change", 32'(duty_out), 32'h111);
        for (int k = 0; k < 20 && m_pc != 6; k++) cyc();
        step = 1'b1; cyc(); step = 1'b0;
        for (int k = 0; k < 20 && m_pc != PER - 1; k++) cyc();
        check("s5_before_bnd", 32'(duty_out), 32'h111);
        check("s5_count_before", 32'(count), 32'd2);
        cyc();
        check("s5_after_bnd", 32'(duty_out), 32'h222);
        check("s5_one_pop", 32'(count), 32'd1);
        for (int k = 0; k < PER; k++) cyc();
        check("s5_still_one_pop", 32'(count), 32'd1);
        enable = 1'b0;
        cyc();

        // Scenario 6: asynchronous reset mid-period during RUN
        do_reset();
        mode = 1'b0;
        for (int i = 0; i < 6; i++) push_word(12'hEEE);
        enable = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) cyc();
        check("s6_pwm_high", 32'(pwm), 32'h7);
        check("s6_queued", 32'(count), 32'd5);
        #3;
        rst = 1'b0;
        #1;
        check("s6_async_pwm", 32'(pwm), 32'h0);
        model_reset();
        check("s6_count", 32'(count), 32'd0);
        check("s6_empty", 32'(empty), 32'h1);
        check("s6_duty", 32'(duty_out), 32'h0);
        #1;
        rst = 1'b1;
        cyc();
        push_word(12'h9F4);
        cyc();
        check("s6_restart", 32'(duty_out), 32'h9F4);

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            tick    = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 40) != 0);
            if ($urandom_range(0, 60) == 0) mode = ~mode;
            if ($urandom_range(0, 30) == 0) hold = 8'($urandom_range(0, 3));
            step    = ($urandom_range(0, 12) == 0);
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_data = 12'($urandom);
            cyc();
        end
        wr_en = 1'b0; step = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
